// File: rtl/cpu_pipe_pkg.sv
// Shared types for the EX-stage forwarding/hazard logic: mux select codes,
// the shadow pipeline stage record, and the "stage writes register" predicate.
package cpu_pipe_pkg;

   localparam int unsigned RD_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic            valid;
      logic            wr;
      logic            load;
      logic [RD_W-1:0] rd;
   } shadow_stage_t;

   // r0 is hardwired to zero in most ISAs, so its result is normally never forwarded.
   function automatic logic writes_reg(shadow_stage_t s, logic [RD_W-1:0] r, logic fwd_r0);
      return s.valid & s.wr & (s.rd == r) & ((s.rd != '0) | fwd_r0);
   endfunction

endpackage

// File: rtl/fwd_compare.sv
// Per-operand forwarding decision: picks the newest in-flight producer of
// one ID-stage source register, or the register file when none exists.
module fwd_compare
   import cpu_pipe_pkg::*;
#(
   parameter bit FWD_R0 = 1'b0
) (
   input  logic [RD_W-1:0] src,
   input  logic            used,
   input  shadow_stage_t   ex,
   input  shadow_stage_t   mem,
   output fwd_sel_e        sel
);

   logic unused_load;
   assign unused_load = ex.load ^ mem.load;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel = FWD_RF;
      if (used && writes_reg(ex, src, FWD_R0)) begin
         sel = FWD_MEM;
      end else if (used && writes_reg(mem, src, FWD_R0)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow EX/MEM/WB destination tracking beside ID/EX: registered operand
// forwarding selects plus the combinational one-cycle load-use stall.
module fwd_hazard_unit
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter bit          FWD_R0     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_freeze,
   input  logic                  branch_flush,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic                  id_reg_write,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_mem_read,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall,
   output logic                  bubble_ex
);

   shadow_stage_t ex_q, mem_q, wb_q;
   fwd_sel_e      sel_a, sel_b;
   logic [RD_W-1:0] rs, rt, rd;
   logic          load_use;
   logic          kill;

   // Register addresses are carried at the package-wide shadow width.
   assign rs = RD_W'(id_rs);
   assign rt = RD_W'(id_rt);
   assign rd = RD_W'(id_rd);

   fwd_compare #(.FWD_R0(FWD_R0)) u_cmp_a (
      .src  (rs),
      .used (id_rs_used),
      .ex   (ex_q),
      .mem  (mem_q),
      .sel  (sel_a)
   );

   fwd_compare #(.FWD_R0(FWD_R0)) u_cmp_b (
      .src  (rt),
      .used (id_rt_used),
      .ex   (ex_q),
      .mem  (mem_q),
      .sel  (sel_b)
   );

   // A load's data is not available until MEM, so an EX-stage load consumer must wait.
   assign load_use = id_valid & ~branch_flush
                   & ex_q.valid & ex_q.load & ex_q.wr & (ex_q.rd != '0)
                   & ((id_rs_used & (rs == ex_q.rd)) | (id_rt_used & (rt == ex_q.rd)));

   assign stall     = load_use & ~pipe_freeze;
   assign bubble_ex = stall;
   assign kill      = stall | branch_flush | ~id_valid;

   // WB is kept to mirror the real pipeline depth; no select currently reads it.
   logic unused_wb;
   assign unused_wb = ^wb_q;

   // NOTE: sequential state uses non-blocking assignments so WB<=MEM<=EX shift in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else if (!pipe_freeze) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (kill) begin
            ex_q      <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
         end else begin
            ex_q      <= '{valid: 1'b1, wr: id_reg_write, load: id_mem_read, rd: rd};
            fwd_a_sel <= sel_a;
            fwd_b_sel <= sel_b;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: one instance with FWD_R0=0 and one with
// FWD_R0=1 share all stimulus; expected selects are queued at issue time.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pipe_freeze, branch_flush, id_valid;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_rs_used, id_rt_used, id_reg_write, id_mem_read;
   logic [1:0] fwd_a_sel, fwd_b_sel, r0_a_sel, r0_b_sel;
   logic       stall, bubble_ex, r0_stall, r0_bubble;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_R0(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .pipe_freeze(pipe_freeze), .branch_flush(branch_flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
      .id_rt_used(id_rt_used), .id_reg_write(id_reg_write), .id_rd(id_rd),
      .id_mem_read(id_mem_read), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall(stall), .bubble_ex(bubble_ex)
   );

   fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_R0(1'b1)) dut_r0 (
      .clk(clk), .rst_n(rst_n), .pipe_freeze(pipe_freeze), .branch_flush(branch_flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
      .id_rt_used(id_rt_used), .id_reg_write(id_reg_write), .id_rd(id_rd),
      .id_mem_read(id_mem_read), .fwd_a_sel(r0_a_sel), .fwd_b_sel(r0_b_sel),
      .stall(r0_stall), .bubble_ex(r0_bubble)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic wr,
                        input logic [4:0] rd, input logic ld, input logic fl, input logic fz);
      id_valid     = v;
      id_rs        = rs;
      id_rs_used   = rsu;
      id_rt        = rt;
      id_rt_used   = rtu;
      id_reg_write = wr;
      id_rd        = rd;
      id_mem_read  = ld;
      branch_flush = fl;
      pipe_freeze  = fz;
   endtask

   // One ID-stage cycle: stall checked combinationally, selects checked after the edge.
   // ra/rb = 2'b11 means the FWD_R0=1 instance expects the same selects.
   task automatic issue(input string tag, input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic wr, input logic [4:0] rd,
                        input logic ld, input logic fl, input logic fz,
                        input logic [1:0] ea, input logic [1:0] eb, input logic es,
                        input logic [1:0] ra, input logic [1:0] rb);
      logic [7:0] exp_v;
      @(negedge clk);
      drive(v, rs, rsu, rt, rtu, wr, rd, ld, fl, fz);
      #1;
      check({tag, " stall"}, 8'(stall), 8'(es));
      check({tag, " bubble"}, 8'(bubble_ex), 8'(es));
      check({tag, " r0.stall"}, 8'(r0_stall), 8'(es));
      sb.push_back({ea, eb, (ra == 2'b11) ? ea : ra, (rb == 2'b11) ? eb : rb});
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      check({tag, " sel"}, {4'b0, fwd_a_sel, fwd_b_sel}, {4'b0, exp_v[7:4]});
      check({tag, " r0.sel"}, {4'b0, r0_a_sel, r0_b_sel}, {4'b0, exp_v[3:0]});
   endtask

   task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es = 1'b0, input logic fl = 1'b0, input logic fz = 1'b0,
                      input logic [1:0] ra = 2'b11, input logic [1:0] rb = 2'b11);
      issue(tag, 1'b1, rs, 1'b1, rt, 1'b1, 1'b1, rd, 1'b0, fl, fz, ea, eb, es, ra, rb);
   endtask

   task automatic lw(input string tag, input logic [4:0] rd, input logic [4:0] rs,
                     input logic [1:0] ea);
      issue(tag, 1'b1, rs, 1'b1, 5'd0, 1'b0, 1'b1, rd, 1'b1, 1'b0, 1'b0, ea, 2'b00, 1'b0,
            2'b11, 2'b11);
   endtask

   task automatic nops(input string tag, input int n);
      for (int i = 0; i < n; i++)
         issue(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
               2'b00, 2'b00, 1'b0, 2'b11, 2'b11);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check("reset stall", 8'(stall), 8'd0);
      check("reset sel", {4'b0, fwd_a_sel, fwd_b_sel}, 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // back-to-back ALU dependency
      alu("t1.prod", 5'd1, 5'd5, 5'd6, 2'b00, 2'b00);
      alu("t1.cons", 5'd2, 5'd1, 5'd7, 2'b10, 2'b00);
      nops("t1.drain", 3);

      // one instruction gap -> MEM/WB value
      alu("t2.prod", 5'd1, 5'd5, 5'd6, 2'b00, 2'b00);
      nops("t2.gap", 1);
      alu("t2.cons", 5'd3, 5'd9, 5'd1, 2'b00, 2'b01);
      nops("t2.drain", 3);

      // two producers of r3, newest wins
      alu("t3.old", 5'd3, 5'd5, 5'd6, 2'b00, 2'b00);
      alu("t3.new", 5'd3, 5'd5, 5'd6, 2'b00, 2'b00);
      alu("t3.cons", 5'd4, 5'd3, 5'd3, 2'b10, 2'b10);
      nops("t3.drain", 3);

      // load-use: one stall cycle, bubble in EX, then MEM/WB forward
      lw("t4.ld", 5'd4, 5'd6, 2'b00);
      alu("t4.stall", 5'd5, 5'd4, 5'd6, 2'b00, 2'b00, 1'b1);
      check("t4.bubble ex.valid", 8'(dut.ex_q.valid), 8'd0);
      alu("t4.go", 5'd5, 5'd4, 5'd6, 2'b01, 2'b00);
      nops("t4.drain", 3);

      // r0 destination: no forward unless FWD_R0=1
      alu("t5.prod", 5'd0, 5'd5, 5'd6, 2'b00, 2'b00);
      alu("t5.cons", 5'd2, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
      nops("t5.drain", 3);

      // flush beats load-use
      lw("t6.ld", 5'd4, 5'd6, 2'b00);
      alu("t6.flush", 5'd5, 5'd4, 5'd6, 2'b00, 2'b00, 1'b0, 1'b1);
      nops("t6.drain", 3);

      // freeze holds selects and shadow state
      alu("f.prod", 5'd1, 5'd5, 5'd6, 2'b00, 2'b00);
      alu("f.cons", 5'd2, 5'd1, 5'd7, 2'b10, 2'b00);
      for (int i = 0; i < 3; i++)
         alu("f.hold", 5'd8, 5'd1, 5'd1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
      alu("f.go", 5'd8, 5'd1, 5'd1, 2'b01, 2'b01);
      nops("f.drain", 3);

      // freeze masks the load-use stall until released
      lw("fl.ld", 5'd4, 5'd6, 2'b00);
      alu("fl.frz", 5'd5, 5'd4, 5'd6, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      alu("fl.stall", 5'd5, 5'd4, 5'd6, 2'b00, 2'b00, 1'b1);
      alu("fl.go", 5'd5, 5'd4, 5'd6, 2'b01, 2'b00);
      nops("fl.drain", 3);

      // reset asserted mid-stall
      alu("r.prod", 5'd7, 5'd5, 5'd6, 2'b00, 2'b00);
      lw("r.ld", 5'd4, 5'd7, 2'b10);
      @(negedge clk);
      drive(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      #1;
      check("r.pre stall", 8'(stall), 8'd1);
      check("r.pre sel", {4'b0, fwd_a_sel, fwd_b_sel}, 8'h08);
      rst_n = 1'b0;
      #1;
      check("r.async stall", 8'(stall), 8'd0);
      check("r.async bubble", 8'(bubble_ex), 8'd0);
      check("r.async sel", {4'b0, fwd_a_sel, fwd_b_sel}, 8'd0);
      check("r.async r0.sel", {4'b0, r0_a_sel, r0_b_sel}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      alu("r.after", 5'd5, 5'd4, 5'd6, 2'b00, 2'b00);
      nops("r.drain", 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
